// File: rtl/oled_pkg.sv
// Shared constants, command codes and FSM state type for the OLED SPI sink.
package oled_pkg;

  localparam int unsigned WIDTH  = 96;
  localparam int unsigned HEIGHT = 64;

  localparam logic [7:0] CMD_SET_COL = 8'h15;
  localparam logic [7:0] CMD_SET_ROW = 8'h75;

  typedef enum logic [2:0] {
    IDLE,
    COL_S,
    COL_E,
    ROW_S,
    ROW_E
  } cmd_state_t;

  function automatic int unsigned clamp_addr(input int unsigned v, input int unsigned max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/spi_byte_deserializer.sv
// Synchronises the SPI link, detects sclk rising edges and assembles MSB-first bytes.
module spi_byte_deserializer #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sclk,
  input  logic       i_sdin,
  input  logic       i_cs_n,
  input  logic       i_d_cn,
  input  logic       i_resn,
  output logic       o_resn_sync,
  output logic       o_done,
  output logic [7:0] o_done_byte,
  output logic       o_done_is_data,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_byte_is_data
);

  logic [SYNC_STAGES-1:0] r_sclk_s;
  logic [SYNC_STAGES-1:0] r_sdin_s;
  logic [SYNC_STAGES-1:0] r_cs_s;
  logic [SYNC_STAGES-1:0] r_dcn_s;
  logic [SYNC_STAGES-1:0] r_resn_s;
  logic                   r_sclk_d;
  logic [7:0]             r_shift;
  logic [2:0]             r_bit_cnt;

  logic       w_sclk;
  logic       w_sdin;
  logic       w_cs_n;
  logic       w_dcn;
  logic       w_resn;
  logic       w_rise;
  logic [7:0] w_shift_nxt;

  // Synchroniser chains; link idle levels are restored on reset so no stray edge appears.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sclk_s <= '0;
      r_sdin_s <= '0;
      r_cs_s   <= '1;
      r_dcn_s  <= '0;
      r_resn_s <= '1;
      r_sclk_d <= 1'b0;
    end else begin
      r_sclk_s <= (r_sclk_s << 1) | SYNC_STAGES'(i_sclk);
      r_sdin_s <= (r_sdin_s << 1) | SYNC_STAGES'(i_sdin);
      r_cs_s   <= (r_cs_s   << 1) | SYNC_STAGES'(i_cs_n);
      r_dcn_s  <= (r_dcn_s  << 1) | SYNC_STAGES'(i_d_cn);
      r_resn_s <= (r_resn_s << 1) | SYNC_STAGES'(i_resn);
      r_sclk_d <= w_sclk;
    end
  end

  assign w_sclk      = r_sclk_s[SYNC_STAGES-1];
  assign w_sdin      = r_sdin_s[SYNC_STAGES-1];
  assign w_cs_n      = r_cs_s[SYNC_STAGES-1];
  assign w_dcn       = r_dcn_s[SYNC_STAGES-1];
  assign w_resn      = r_resn_s[SYNC_STAGES-1];
  assign w_rise      = w_sclk & ~r_sclk_d;
  assign w_shift_nxt = {r_shift[6:0], w_sdin};

  assign o_resn_sync    = w_resn;
  assign o_done         = w_rise & ~w_cs_n & w_resn & (r_bit_cnt == 3'd7);
  assign o_done_byte    = w_shift_nxt;
  assign o_done_is_data = w_dcn;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift        <= '0;
      r_bit_cnt      <= '0;
      o_byte_valid   <= 1'b0;
      o_byte_data    <= '0;
      o_byte_is_data <= 1'b0;
    end else if (!w_resn) begin
      r_shift        <= '0;
      r_bit_cnt      <= '0;
      o_byte_valid   <= 1'b0;
      o_byte_data    <= '0;
      o_byte_is_data <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      if (w_cs_n) begin
        r_bit_cnt <= '0;
      end else if (w_rise) begin
        r_shift   <= w_shift_nxt;
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (o_done) begin
          o_byte_valid   <= 1'b1;
          o_byte_data    <= w_shift_nxt;
          o_byte_is_data <= w_dcn;
        end
      end
    end
  end

endmodule

// File: rtl/oled_spi_sink.sv
// Receive-side model of the PmodOLED link: command FSM, address window and RGB565 pixel strobes.
module oled_spi_sink #(
  parameter int unsigned WIDTH       = oled_pkg::WIDTH,
  parameter int unsigned HEIGHT      = oled_pkg::HEIGHT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        sdin,
  input  logic        cs,
  input  logic        d_cn,
  input  logic        resn,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_is_data,
  output logic        pix_valid,
  output logic [6:0]  pix_x,
  output logic [5:0]  pix_y,
  output logic [15:0] pix_color,
  output logic        frame_done
);

  import oled_pkg::*;

  typedef struct packed {
    cmd_state_t st;
    logic [6:0] pend;
    logic [6:0] col_start;
    logic [6:0] col_end;
    logic [5:0] row_start;
    logic [5:0] row_end;
    logic [6:0] cur_x;
    logic [5:0] cur_y;
    logic       phase;
    logic [7:0] hi;
  } sink_ctx_t;

  localparam sink_ctx_t CTX_RESET = '{
    st:        IDLE,
    pend:      '0,
    col_start: '0,
    col_end:   7'(WIDTH - 1),
    row_start: '0,
    row_end:   6'(HEIGHT - 1),
    cur_x:     '0,
    cur_y:     '0,
    phase:     1'b0,
    hi:        '0
  };

  logic       w_resn;
  logic       w_done;
  logic [7:0] w_done_byte;
  logic       w_done_is_data;
  logic [6:0] w_col_clamp;
  logic [5:0] w_row_clamp;
  logic [6:0] w_col_end;
  logic [5:0] w_row_end;
  logic       w_pix_fire;
  logic       w_frame_fire;
  sink_ctx_t  w_ctx_nxt;
  sink_ctx_t  r_ctx;

  spi_byte_deserializer #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_deser (
    .i_clk          (clk),
    .i_rst          (reset),
    .i_sclk         (sclk),
    .i_sdin         (sdin),
    .i_cs_n         (cs),
    .i_d_cn         (d_cn),
    .i_resn         (resn),
    .o_resn_sync    (w_resn),
    .o_done         (w_done),
    .o_done_byte    (w_done_byte),
    .o_done_is_data (w_done_is_data),
    .o_byte_valid   (byte_valid),
    .o_byte_data    (byte_data),
    .o_byte_is_data (byte_is_data)
  );

  assign w_col_clamp = 7'(clamp_addr(32'(w_done_byte[6:0]), WIDTH - 1));
  assign w_row_clamp = 6'(clamp_addr(32'(w_done_byte[5:0]), HEIGHT - 1));
  assign w_col_end   = (w_col_clamp < r_ctx.pend)      ? r_ctx.pend      : w_col_clamp;
  assign w_row_end   = (w_row_clamp < r_ctx.pend[5:0]) ? r_ctx.pend[5:0] : w_row_clamp;

  // The pixel strobe is decided from the completing byte so it lands on the same edge as byte_valid.
  always_comb begin
    w_ctx_nxt    = r_ctx;
    w_pix_fire   = 1'b0;
    w_frame_fire = 1'b0;
    if (w_done) begin
      if (!w_done_is_data) begin
        w_ctx_nxt.phase = 1'b0;
        case (r_ctx.st)
          IDLE: begin
            if (w_done_byte == CMD_SET_COL)      w_ctx_nxt.st = COL_S;
            else if (w_done_byte == CMD_SET_ROW) w_ctx_nxt.st = ROW_S;
          end
          COL_S: begin
            w_ctx_nxt.pend = w_col_clamp;
            w_ctx_nxt.st   = COL_E;
          end
          COL_E: begin
            w_ctx_nxt.col_start = r_ctx.pend;
            w_ctx_nxt.col_end   = w_col_end;
            w_ctx_nxt.cur_x     = r_ctx.pend;
            w_ctx_nxt.st        = IDLE;
          end
          ROW_S: begin
            w_ctx_nxt.pend = {1'b0, w_row_clamp};
            w_ctx_nxt.st   = ROW_E;
          end
          ROW_E: begin
            w_ctx_nxt.row_start = r_ctx.pend[5:0];
            w_ctx_nxt.row_end   = w_row_end;
            w_ctx_nxt.cur_y     = r_ctx.pend[5:0];
            w_ctx_nxt.st        = IDLE;
          end
          default: w_ctx_nxt.st = IDLE;
        endcase
      end else if (!r_ctx.phase) begin
        w_ctx_nxt.hi    = w_done_byte;
        w_ctx_nxt.phase = 1'b1;
      end else begin
        w_ctx_nxt.phase = 1'b0;
        w_pix_fire      = 1'b1;
        if (r_ctx.cur_x == r_ctx.col_end) begin
          w_ctx_nxt.cur_x = r_ctx.col_start;
          if (r_ctx.cur_y == r_ctx.row_end) begin
            w_ctx_nxt.cur_y = r_ctx.row_start;
            w_frame_fire    = 1'b1;
          end else begin
            w_ctx_nxt.cur_y = r_ctx.cur_y + 6'd1;
          end
        end else begin
          w_ctx_nxt.cur_x = r_ctx.cur_x + 7'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctx      <= CTX_RESET;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_color  <= '0;
      frame_done <= 1'b0;
    end else if (!w_resn) begin
      r_ctx      <= CTX_RESET;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_color  <= '0;
      frame_done <= 1'b0;
    end else begin
      r_ctx      <= w_ctx_nxt;
      pix_valid  <= w_pix_fire;
      frame_done <= w_frame_fire;
      if (w_pix_fire) begin
        pix_x     <= r_ctx.cur_x;
        pix_y     <= r_ctx.cur_y;
        pix_color <= {r_ctx.hi, w_done_byte};
      end
    end
  end

endmodule

// File: tb/tb_oled_spi_sink.sv
// Directed bench for oled_spi_sink with a byte/pixel reference model and a per-cycle compare process.
module tb_oled_spi_sink;

  // Row count reduced so a full-frame walk stays short.
  localparam int TW = 96;
  localparam int TH = 8;

  logic        clk = 1'b0;
  logic        reset, sclk, sdin, cs, d_cn, resn;
  logic        byte_valid, byte_is_data, pix_valid, frame_done;
  logic [7:0]  byte_data;
  logic [6:0]  pix_x;
  logic [5:0]  pix_y;
  logic [15:0] pix_color;

  always #5 clk = ~clk;

  oled_spi_sink #(
    .WIDTH(TW),
    .HEIGHT(TH),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .sdin(sdin), .cs(cs), .d_cn(d_cn), .resn(resn),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_data(byte_is_data),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .frame_done(frame_done)
  );

  typedef struct { int x; int y; int color; int fd; } pix_t;
  typedef struct { int data; int dc; } byte_t;

  pix_t  exp_pix[$];
  pix_t  obs_pix[$];
  byte_t exp_byte[$];
  pix_t  p_e, p_o;
  byte_t b_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise = 0;
  int n_bytes = 0;

  // Reference model state: window, offsets inside it, pending high byte, command progress.
  int m_cs, m_ce, m_rs, m_re, m_pend, m_coff, m_roff, m_phase, m_hi, m_st;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_reset();
    m_cs = 0; m_ce = TW - 1; m_rs = 0; m_re = TH - 1;
    m_pend = 0; m_coff = 0; m_roff = 0; m_phase = 0; m_hi = 0; m_st = 0;
  endfunction

  function automatic void model_byte(input int b, input int dc);
    pix_t p;
    byte_t e;
    int w, h, v;
    e.data = b; e.dc = dc;
    exp_byte.push_back(e);
    if (dc == 0) begin
      m_phase = 0;
      case (m_st)
        0: m_st = (b == 'h15) ? 1 : (b == 'h75) ? 3 : 0;
        1: begin m_pend = imin(b % 128, TW - 1); m_st = 2; end
        2: begin
          v = imin(b % 128, TW - 1);
          m_cs = m_pend; m_ce = (v < m_pend) ? m_pend : v; m_coff = 0; m_st = 0;
        end
        3: begin m_pend = imin(b % 64, TH - 1); m_st = 4; end
        default: begin
          v = imin(b % 64, TH - 1);
          m_rs = m_pend; m_re = (v < m_pend) ? m_pend : v; m_roff = 0; m_st = 0;
        end
      endcase
    end else if (m_phase == 0) begin
      m_hi = b; m_phase = 1;
    end else begin
      w = m_ce - m_cs + 1;
      h = m_re - m_rs + 1;
      p.x = m_cs + m_coff; p.y = m_rs + m_roff; p.color = m_hi * 256 + b;
      p.fd = (m_coff == w - 1 && m_roff == h - 1) ? 1 : 0;
      exp_pix.push_back(p);
      m_phase = 0;
      m_coff++;
      if (m_coff == w) begin
        m_coff = 0;
        m_roff = (m_roff == h - 1) ? 0 : m_roff + 1;
      end
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (byte_valid) begin
        n_bytes++;
        if (exp_byte.size() == 0) chk("unexpected_byte", 1, 0);
        else begin
          b_e = exp_byte.pop_front();
          chk("byte_data", byte_data, b_e.data);
          chk("byte_is_data", byte_is_data, b_e.dc);
          chk("byte_latency", cyc - last_rise, 3);
        end
      end
      if (pix_valid) begin
        p_o.x = pix_x; p_o.y = pix_y; p_o.color = pix_color; p_o.fd = frame_done;
        obs_pix.push_back(p_o);
        chk("pix_with_byte", byte_valid, 1);
        if (exp_pix.size() == 0) chk("unexpected_pix", 1, 0);
        else begin
          p_e = exp_pix.pop_front();
          chk("pix_x", p_o.x, p_e.x);
          chk("pix_y", p_o.y, p_e.y);
          chk("pix_color", p_o.color, p_e.color);
          chk("frame_done", p_o.fd, p_e.fd);
        end
      end else if (frame_done) begin
        chk("frame_done_alone", 1, 0);
      end
    end
  end

  task automatic spi_bits(input logic [7:0] b, input int n, input logic dc);
    d_cn = dc;
    cs   = 1'b0;
    for (int i = 0; i < n; i++) begin
      sdin = b[7-i];
      sclk = 1'b0;
      repeat (2) @(negedge clk);
      sclk = 1'b1;
      if (i == 7) last_rise = cyc;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, input logic dc);
    model_byte(int'(b), int'(dc));
    spi_bits(b, 8, dc);
  endtask

  task automatic park();
    sclk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    repeat (8) @(negedge clk);
    chk({tag, "_bytes_left"}, exp_byte.size(), 0);
    chk({tag, "_pix_left"}, exp_pix.size(), 0);
  endtask

  task automatic chk_obs(input int idx, input int x, input int y, input int fd);
    if (idx >= obs_pix.size()) chk("obs_missing", obs_pix.size(), idx + 1);
    else begin
      chk("obs_x", obs_pix[idx].x, x);
      chk("obs_y", obs_pix[idx].y, y);
      chk("obs_fd", obs_pix[idx].fd, fd);
    end
  endtask

  task automatic do_reset();
    park();
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  int fd_count;

  initial begin
    reset = 1'b1; sclk = 1'b0; sdin = 1'b0; cs = 1'b1; d_cn = 1'b0; resn = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_byte_data", byte_data, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_color", pix_color, 0);
    chk("rst_frame_done", frame_done, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the middle of a byte
    spi_byte(8'h5A, 1'b0);
    drain("pre");
    chk("pre_byte_data", byte_data, 'h5A);
    spi_bits(8'hFF, 4, 1'b0);
    do_reset();
    chk("mid_rst_byte_data", byte_data, 0);
    chk("mid_rst_byte_valid", byte_valid, 0);
    n_bytes = 0;
    spi_byte(8'h3C, 1'b0);
    drain("rst");
    chk("rst_one_byte", n_bytes, 1);
    chk("rst_byte_3c", byte_data, 'h3C);

    // Window 16..18 x 5..6
    obs_pix.delete();
    spi_byte(8'h15, 1'b0); spi_byte(8'h10, 1'b0); spi_byte(8'h12, 1'b0);
    spi_byte(8'h75, 1'b0); spi_byte(8'h05, 1'b0); spi_byte(8'h06, 1'b0);
    for (int i = 0; i < 12; i++) spi_byte(8'(8'h21 + i * 3), 1'b1);
    drain("win");
    chk("win_count", obs_pix.size(), 6);
    chk_obs(0, 16, 5, 0);
    chk_obs(2, 18, 5, 0);
    chk_obs(3, 16, 6, 0);
    chk_obs(5, 18, 6, 1);
    chk("win_color0", (obs_pix.size() > 0) ? obs_pix[0].color : -1, 'h2124);

    // Full frame over the default window
    do_reset();
    obs_pix.delete();
    for (int i = 0; i < 2 * TW * TH; i++) spi_byte(8'(i * 7 + 3), 1'b1);
    drain("frame");
    chk("frame_count", obs_pix.size(), TW * TH);
    fd_count = 0;
    foreach (obs_pix[i]) fd_count += obs_pix[i].fd;
    chk("frame_fd_count", fd_count, 1);
    chk_obs(TW * TH - 1, TW - 1, TH - 1, 1);
    spi_byte(8'h12, 1'b1); spi_byte(8'h34, 1'b1);
    drain("wrap");
    chk_obs(TW * TH, 0, 0, 0);

    // Partial byte discarded by cs high
    n_bytes = 0;
    spi_bits(8'h55, 5, 1'b0);
    park();
    cs = 1'b1;
    repeat (6) @(negedge clk);
    spi_byte(8'hA5, 1'b0);
    drain("part");
    chk("part_one_byte", n_bytes, 1);
    chk("part_byte_a5", byte_data, 'hA5);

    // Orphan high byte dropped by a command
    obs_pix.delete();
    spi_byte(8'hF8, 1'b1); spi_byte(8'hAF, 1'b0);
    spi_byte(8'h07, 1'b1); spi_byte(8'hE0, 1'b1);
    drain("orph");
    chk("orph_count", obs_pix.size(), 1);
    chk("orph_color", (obs_pix.size() > 0) ? obs_pix[0].color : -1, 'h07E0);

    // Clamped single-column window, then soft reset via resn
    obs_pix.delete();
    spi_byte(8'h15, 1'b0); spi_byte(8'h70, 1'b0); spi_byte(8'h60, 1'b0);
    for (int i = 0; i < 6; i++) spi_byte(8'(8'h40 + i), 1'b1);
    drain("clamp");
    chk("clamp_count", obs_pix.size(), 3);
    chk_obs(0, TW - 1, 0, 0);
    chk_obs(1, TW - 1, 1, 0);
    chk_obs(2, TW - 1, 2, 0);
    park();
    resn = 1'b0;
    repeat (10) @(negedge clk);
    chk("resn_pix_x", pix_x, 0);
    chk("resn_byte_data", byte_data, 0);
    model_reset();
    resn = 1'b1;
    repeat (4) @(negedge clk);
    obs_pix.delete();
    for (int i = 0; i < 4; i++) spi_byte(8'(8'h90 + i), 1'b1);
    drain("resn");
    chk_obs(0, 0, 0, 0);
    chk_obs(1, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/oled_spi_sink.md
Name: oled_spi_sink

Overview:
- Receive-side model of the SSD1331-style PmodOLED SPI link driven by the OLED display controller.
- Deserialises cs/sdin/sclk/d_cn into bytes and tracks the column/row address window.
- Assembles RGB565 pixels and emits one write strobe per pixel with its (x, y) coordinate.
- Used for display-less loopback checking on the board and as the scoreboard front end in the OLED benches.

Parameters:
- WIDTH, 96, display columns; x range 0..WIDTH-1.
- HEIGHT, 64, display rows; y range 0..HEIGHT-1.
- SYNC_STAGES, 2, synchroniser depth on every link input.

Ports:
- clk  in  1  system clock (100 MHz); must be at least 4x the sclk rate.
- reset  in  1  asynchronous, active-high reset.
- sclk  in  1  link serial clock; data is sampled on its rising edge.
- sdin  in  1  link serial data, MSB first.
- cs  in  1  link chip select, active low.
- d_cn  in  1  byte type: 0 = command, 1 = data.
- resn  in  1  display reset, active low; acts as a soft reset.
- byte_valid  out  1  one-cycle pulse when a byte completes.
- byte_data  out  8  the completed byte.
- byte_is_data  out  1  value of d_cn sampled at the 8th bit.
- pix_valid  out  1  one-cycle pixel write strobe.
- pix_x  out  7  column of the pixel being written.
- pix_y  out  6  row of the pixel being written.
- pix_color  out  16  RGB565 value {high byte, low byte}.
- frame_done  out  1  one-cycle pulse on the pixel written at (col_end, row_end).

Behaviour:
- Reset (async) values: all outputs 0; window col 0..WIDTH-1, row 0..HEIGHT-1; cur_x = 0, cur_y = 0; pixel phase 0; FSM in IDLE; bit_cnt 0.
- Synchronisation: sclk, sdin, cs, d_cn and resn each pass through SYNC_STAGES flops. A rising edge is detected from the synchronised sclk and one further delay flop.
- Shifting: on a detected rising edge with synchronised cs low, shift sdin in MSB first and increment bit_cnt.
- Byte completion: on the 8th bit, register byte_valid, byte_data and byte_is_data. byte_valid is visible SYNC_STAGES+1 clk edges after the first clk edge that samples the raw sclk rise.
- cs high: clears bit_cnt and discards the partial byte; no byte_valid is produced. Pixel phase and FSM state are retained.
- resn low (synchronised): same effect as reset on all state and outputs. Bytes are ignored while resn is low.
- Command FSM (acts on command bytes only):
  - IDLE: 0x15 -> COL_S; 0x75 -> ROW_S; any other byte is ignored and the FSM stays in IDLE.
  - COL_S: store byte & 0x7F, clamped to WIDTH-1 -> COL_E.
  - COL_E: store clamped end; if end < start, end = start. Commit the window, set cur_x = col_start -> IDLE.
  - ROW_S and ROW_E: identical, with mask 0x3F and clamp HEIGHT-1; ROW_E sets cur_y = row_start.
  - Any command byte arriving while pixel phase = 1 drops the pending high byte (phase = 0).
- Data bytes:
  - Phase 0: latch the high byte and set phase = 1.
  - Phase 1: assert pix_valid in the same cycle as that byte's byte_valid, with the current cur_x, cur_y and {hi, lo}; then set phase = 0.
  - Data bytes are ignored by the FSM, so an FSM in a non-IDLE state holds until the next command byte.
- Address advance after each pixel:
  - cur_x == col_end: cur_x = col_start, then:
    - cur_y == row_end: cur_y = row_start and pulse frame_done.
    - otherwise: cur_y + 1.
  - otherwise: cur_x + 1.
  - A 1-column or 1-row window is legal.
- Only one byte can complete per cycle, so byte events never coincide.

Decomposition:
- Package oled_pkg holds WIDTH, HEIGHT, CMD_SET_COL = 8'h15, CMD_SET_ROW = 8'h75 and the FSM state enum (IDLE, COL_S, COL_E, ROW_S, ROW_E).
- Sub-module spi_byte_deserializer contains the synchronisers, edge detect, shift register, bit_cnt and the byte_valid/byte_data/byte_is_data registers.
- oled_spi_sink contains the FSM, address window and pixel assembly.

Test Plan:
- Reset: assert reset mid-byte (after 4 bits) -> all outputs 0. A following 8-bit byte 0x3C yields exactly one byte_valid with byte_data 0x3C.
- Window: commands 0x15,0x10,0x12,0x75,0x05,0x06, then 12 data bytes -> pixels at (16,5),(17,5),(18,5),(16,6),(17,6),(18,6); frame_done only on the 6th pixel.
- Full frame: default window, 12288 data bytes -> 6144 pix_valid, the last at (95,63) with frame_done. The next pixel pair writes (0,0).
- Partial byte: cs raised after 5 bits, then a full byte 0xA5 -> single byte_valid with byte_data 0xA5.
- Orphan byte: data 0xF8, command 0xAF, data 0x07, data 0xE0 -> exactly one pixel, pix_color 0x07E0.
- Clamp and resn: commands 0x15,0x70,0x60 -> window 95..95 (pixels land only at x = 95). Then drive resn low for 10 cycles -> window restored to 0..95 and cur_x = 0.
